fpa_nip_stream: RTL
===================

FPA_NIP_STREAM -- requirements
Module: fpa_nip_stream

Interface
REQ-001 SHALL have parameter MAX_OPS, default 6: maximum operands per sum, legal range 2..16.
REQ-002 SHALL have parameter ACC_W, default 24+clog2(MAX_OPS)+1: signed accumulator width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, 32 bits: IEEE-754 single-precision operand.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-007 SHALL have port in_last, input, 1 bit: current operand ends the sum.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-009 SHALL have port out_data, output, 32 bits: single-precision sum.
REQ-010 SHALL have port out_err, output, 1 bit: sum invalid because of a special operand or exponent overflow.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data and out_err are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCUM, NORM and OUT.
REQ-014 SHALL drive in_ready=1 only in IDLE and ACCUM; an operand is accepted when in_valid=1 and in_ready=1.
REQ-015 SHALL, on accepting an operand in IDLE, load the accumulator, set op_cnt=1, and go to ACCUM; if in_last=1 on that operand it SHALL go directly to NORM.
REQ-016 SHALL, in ACCUM, on each accepted operand add it into the accumulator and increment op_cnt.
REQ-017 SHALL go ACCUM->NORM on the operand with in_last=1, or on the MAX_OPS-th operand regardless of in_last.
REQ-018 SHALL classify each operand as follows:
- exp=0 and mantissa=0: zero, contributes nothing, counts as an operand.
- exp=255: inf/NaN, sets the sticky error bit.
- exp=0 and mantissa!=0: denormal, sets the sticky error bit.
- any other value: normal, magnitude {1,mant[22:0]}, negated (two's complement) when the sign bit is 1.
REQ-019 SHALL align every operand into the accumulator against a running exponent acc_exp:
- E > acc_exp: arithmetic-right-shift the accumulator by E-acc_exp, add the operand, set acc_exp=E.
- E <= acc_exp: right-shift the operand by acc_exp-E, then add.
- Shift amount >= ACC_W: the shifted value becomes 0 (0 or -1 for an arithmetic shift).
- Truncation only; no rounding.
REQ-020 SHALL give the first operand acc_exp=E, or acc_exp=0 if that operand is a zero.
REQ-021 SHALL, in NORM (one cycle), normalise the result:
- sign = acc MSB; mag = |acc|; p = position of mag MSB.
- p>23: shift mag right by p-23 and set exp = acc_exp+(p-23).
- p<23: shift mag left by 23-p and set exp = acc_exp-(23-p).
- Exponent arithmetic SHALL be signed, at least 10 bits wide.
REQ-022 SHALL compute out_data in NORM with this priority:
- sticky error: 0x00000000 with out_err=1.
- mag=0: 0x00000000.
- exp>=255: 0x00000000 with out_err=1.
- exp<=0: 0x00000000 with out_err=0 (flush to zero).
- otherwise: {sign, exp[7:0], mag[22:0]}.
REQ-023 SHALL register the result and assert out_valid in OUT, exactly 2 cycles after the clock edge that accepts the last operand.
REQ-024 SHALL hold out_data, out_err and out_valid stable in OUT until out_ready=1; on that handshake it SHALL return to IDLE and clear the accumulator, acc_exp, op_cnt and the sticky error.
REQ-025 SHALL keep in_ready=0 in NORM and OUT, so an operand presented during OUT is not accepted until the cycle after the handshake.
REQ-026 SHALL make out_data and out_err zero whenever out_valid=0.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, force the following, regardless of state, including mid-ACCUM and mid-OUT:
- FSM=IDLE.
- out_valid=0, out_data=0, out_err=0.
- accumulator, acc_exp, op_cnt and sticky error cleared.
REQ-028 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-029 SHALL discard any partial sum when reset is applied, with no output produced.

Verification
REQ-030 SHALL be verified with 0x3F800000, then 0x40000000 with in_last -> out_data=0x40400000, out_err=0, out_valid exactly 2 cycles after the last accept.
REQ-031 SHALL be verified with six 0x3F800000 operands and in_last never set -> out_data=0x40C00000 after the 6th operand.
REQ-032 SHALL be verified with 0x3FC00000, then 0xBFC00000 with in_last -> out_data=0x00000000, out_err=0.
REQ-033 SHALL be verified with 0x40000000, 0x7F800000 and 0x3F800000 with in_last -> out_data=0x00000000, out_err=1.
REQ-034 SHALL be verified with 0x41200000, 0x3F800000 and 0xC0000000 with in_last, while out_ready is held 0 for 5 cycles -> out_data=0x41100000 held stable, in_ready=0 until the handshake.
REQ-035 SHALL be verified with two operands accepted, then rst=1 for 1 cycle, then 0x3F800000 with in_last -> out_data=0x3F800000 and no output for the aborted sum.

Source files
------------

// File: rtl/fpa_nip_stream.sv
// Streaming single-precision adder: sums up to MAX_OPS operands through a
// fixed-point accumulator aligned on a running exponent.
// Latency: the result is presented in OUT two cycles after the last operand
// is accepted (one NORM cycle, then the registered result).
// Backpressure: valid/ready on both sides; in_ready is low in NORM and OUT,
// and the result is held in OUT until out_ready.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready
// operand stream; out_data/out_err/out_valid/out_ready result stream.
module fpa_nip_stream #(
  parameter int MAX_OPS = 6,
  parameter int ACC_W   = 24 + $clog2(MAX_OPS) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(MAX_OPS + 1);
  localparam int PW = $clog2(ACC_W);

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [7:0]              acc_exp;
  logic [CW-1:0]           op_cnt;
  logic                    sticky;
  logic                    accept;

  // Operand decode and alignment against the running exponent
  logic [7:0]              op_exp;
  logic [22:0]             op_man;
  logic                    op_zero;
  logic                    op_spec;
  logic signed [ACC_W-1:0] op_val;
  logic signed [ACC_W-1:0] sum_val;
  logic [7:0]              sum_exp;

  always_comb begin
    op_exp  = in_data[30:23];
    op_man  = in_data[22:0];
    op_zero = (op_exp == 8'd0) && (op_man == 23'd0);
    op_spec = (op_exp == 8'hFF) || ((op_exp == 8'd0) && (op_man != 23'd0));
    op_val  = $signed({{(ACC_W-24){1'b0}}, 1'b1, op_man});
    if (in_data[31]) begin
      op_val = -op_val;
    end
    // Whichever side has the smaller exponent is shifted down; >>> with an
    // amount >= ACC_W collapses to 0 or -1, which is the truncated value.
    if (op_exp > acc_exp) begin
      sum_val = (acc >>> (op_exp - acc_exp)) + op_val;
      sum_exp = op_exp;
    end else begin
      sum_val = acc + (op_val >>> (acc_exp - op_exp));
      sum_exp = acc_exp;
    end
  end

  // Normalisation of the accumulator into single precision
  logic                    sgn;
  logic [ACC_W-1:0]        mag;
  logic [ACC_W-1:0]        mag_n;
  logic [PW-1:0]           lead;
  logic signed [11:0]      n_exp;
  logic [31:0]             res_data;
  logic                    res_err;
  logic                    unused_bits;

  always_comb begin
    sgn  = acc[ACC_W-1];
    mag  = sgn ? $unsigned(-acc) : $unsigned(acc);
    lead = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) begin
        lead = PW'(i);
      end
    end
    // Leading one lands on bit 23; exponent moves by the same distance.
    n_exp = $signed({4'b0, acc_exp}) + $signed({{(12-PW){1'b0}}, lead}) - 12'sd23;
    if (lead > PW'(23)) begin
      mag_n = mag >> (lead - PW'(23));
    end else begin
      mag_n = mag << (PW'(23) - lead);
    end
    res_data = 32'h0;
    res_err  = 1'b0;
    if (sticky) begin
      res_err = 1'b1;
    end else if (mag == '0) begin
      res_data = 32'h0;
    end else if (n_exp >= 12'sd255) begin
      res_err = 1'b1;
    end else if (n_exp <= 12'sd0) begin
      res_data = 32'h0;
    end else begin
      res_data = {sgn, n_exp[7:0], mag_n[22:0]};
    end
  end

  assign unused_bits = ^mag_n[ACC_W-1:23];

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = in_last ? NORM : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || (op_cnt == CW'(MAX_OPS - 1)))) begin
          state_nxt = NORM;
        end
      end
      NORM: state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Datapath and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_exp   <= '0;
      op_cnt    <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_cnt <= CW'(1);
            sticky <= op_spec;
            if (op_zero || op_spec) begin
              acc     <= '0;
              acc_exp <= '0;
            end else begin
              acc     <= op_val;
              acc_exp <= op_exp;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            op_cnt <= op_cnt + CW'(1);
            if (op_spec) begin
              sticky <= 1'b1;
            end else if (!op_zero) begin
              acc     <= sum_val;
              acc_exp <= sum_exp;
            end
          end
        end
        NORM: begin
          out_valid <= 1'b1;
          out_data  <= res_data;
          out_err   <= res_err;
        end
        OUT: begin
          if (out_ready) begin
            acc       <= '0;
            acc_exp   <= '0;
            op_cnt    <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
